e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu.sv | 142 ++++++++++++++
 tb/tb_e_mdu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// Multiply/divide unit for the E stage: holds HI/LO, runs MULT/MULTU (5 cycles) and DIV/DIVU (10 cycles).
// Latency: result lands in HI/LO in the first cycle busy is low; MTHI/MTLO write on the next edge; mdu_out is combinational.
// Backpressure: none internally; start/MTHI/MTLO arriving while busy are dropped, and the upstream hazard unit stalls them.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   A, B                - rs/rt operands from the E-stage forwarding mux
//   mdu_op, start       - op code (0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO) and launch pulse
//   busy, HI, LO        - registered status and result registers
//   mdu_out             - MFHI/MFLO read port
module e_mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  mdu_op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] p_hi_q, p_hi_d;
    logic [31:0] p_lo_q, p_lo_d;
    logic        p_wr_q, p_wr_d;

    logic        is_md;
    logic        is_div;
    logic [63:0] res;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] uq, ur;

    assign is_md  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                    (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    assign is_div = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);

    // Launch result. Signed divide goes through magnitudes so that
    // 0x80000000 / -1 wraps to 0x80000000 without relying on the
    // simulator's signed-overflow behaviour. A zero divisor is replaced
    // by 1 only to keep the datapath X-free; the result is discarded.
    always_comb begin
        res    = 64'd0;
        a_neg  = (mdu_op == OP_DIV) && A[31];
        b_neg  = (mdu_op == OP_DIV) && B[31];
        a_mag  = a_neg ? (32'd0 - A) : A;
        b_mag  = b_neg ? (32'd0 - B) : B;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq     = a_mag / b_safe;
        ur     = a_mag % b_safe;
        case (mdu_op)
            OP_MULT:  res = {{32{A[31]}}, A} * {{32{B[31]}}, B};
            OP_MULTU: res = {32'd0, A} * {32'd0, B};
            OP_DIV,
            OP_DIVU:  res = {(a_neg ? (32'd0 - ur) : ur),
                             ((a_neg ^ b_neg) ? (32'd0 - uq) : uq)};
            default:  res = 64'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        p_wr_d  = p_wr_q;
        case (state_q)
            IDLE: begin
                if (start && is_md) begin
                    state_d = RUN;
                    p_hi_d  = res[63:32];
                    p_lo_d  = res[31:0];
                    // Divide by zero still takes the full 10 cycles but leaves HI/LO alone.
                    p_wr_d  = !(is_div && (B == 32'd0));
                    cnt_d   = is_div ? 4'd10 : 4'd5;
                end else if (mdu_op == OP_MTHI) begin
                    hi_d = A;
                end else if (mdu_op == OP_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    if (p_wr_q) begin
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            p_wr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            p_wr_q  <= p_wr_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign mdu_out = (mdu_op == OP_MFHI) ? hi_q :
                     (mdu_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  mdu_op;
    logic        start;
    logic        busy;
    logic [31:0] HI, LO, mdu_out;

    int checks = 0;
    int errors = 0;

    // Architectural model of the visible registers
    logic [31:0] m_hi, m_lo;

    e_mdu dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .mdu_op(mdu_op),
        .start(start), .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what the instruction set says the op produces.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output bit wr);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        sa = longint'(ia);
        sb = longint'(ib);
        wr = 1'b1;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            4'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            4'd2: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
            4'd3: begin
                if (b == 32'd0) wr = 1'b0;
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) wr = 1'b0;
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    // Launch op, hammer the unit with random interfering ops while busy,
    // then check the completion cycle.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e_hi, e_lo;
        bit wr;
        int n;
        ref_op(op, a, b, e_hi, e_lo, wr);
        n = (op >= 4'd3) ? 10 : 5;
        mdu_op = op; A = a; B = b; start = 1'b1;
        tick();
        for (int k = 0; k < n; k++) begin
            mdu_op = 4'($urandom_range(1, 8));
            start  = 1'($urandom_range(0, 1));
            A = $urandom; B = $urandom;
            #1;
            check({tag, " busy"}, {31'd0, busy}, 32'd1);
            check({tag, " hi_hold"}, HI, m_hi);
            check({tag, " lo_hold"}, LO, m_lo);
            if (mdu_op == 4'd7) check({tag, " mfhi_busy"}, mdu_out, m_hi);
            if (mdu_op == 4'd8) check({tag, " mflo_busy"}, mdu_out, m_lo);
            tick();
        end
        mdu_op = 4'd0; start = 1'b0;
        if (wr) begin m_hi = e_hi; m_lo = e_lo; end
        #1;
        check({tag, " busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, " hi"}, HI, m_hi);
        check({tag, " lo"}, LO, m_lo);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        mdu_op = op; A = a; start = 1'b0;
        tick();
        if (op == 4'd5) m_hi = a; else m_lo = a;
        mdu_op = 4'd0;
    endtask

    initial begin
        logic [3:0] op;
        logic [31:0] ra, rb;
        // Reset overrides a simultaneous launch
        reset = 1'b1; mdu_op = 4'd1; start = 1'b1; A = 32'd7; B = 32'd9;
        m_hi = 32'd0; m_lo = 32'd0;
        tick(); tick();
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst hi", HI, 32'd0);
        check("rst lo", LO, 32'd0);
        reset = 1'b0; mdu_op = 4'd0; start = 1'b0;
        #1;
        check("rst mdu_out", mdu_out, 32'd0);

        // Directed cases (first one launches right after reset)
        run_md("mult_neg3x5", 4'd1, 32'hFFFFFFFD, 32'd5);
        check("mult_neg3x5 hi_const", HI, 32'hFFFFFFFF);
        check("mult_neg3x5 lo_const", LO, 32'hFFFFFFF1);
        run_md("multu", 4'd2, 32'hFFFFFFFF, 32'd2);
        check("multu hi_const", HI, 32'h00000001);
        check("multu lo_const", LO, 32'hFFFFFFFE);
        run_md("div_neg7by2", 4'd3, 32'hFFFFFFF9, 32'd2);
        check("div hi_const", HI, 32'hFFFFFFFF);
        check("div lo_const", LO, 32'hFFFFFFFD);
        mt(4'd5, 32'h11);
        mt(4'd6, 32'h22);
        run_md("divu_by0", 4'd4, 32'd7, 32'd0);
        check("divu_by0 hi_const", HI, 32'h11);
        check("divu_by0 lo_const", LO, 32'h22);
        run_md("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf lo_const", LO, 32'h80000000);
        check("div_ovf hi_const", HI, 32'h0);

        // MTHI: old HI visible via MFHI before the edge, new after
        mdu_op = 4'd7; #1;
        check("mfhi before mthi", mdu_out, m_hi);
        mt(4'd5, 32'hDEADBEEF);
        check("mthi hi", HI, 32'hDEADBEEF);
        mdu_op = 4'd7; #1;
        check("mfhi after mthi", mdu_out, 32'hDEADBEEF);
        mdu_op = 4'd8; #1;
        check("mflo", mdu_out, m_lo);

        // start with non-launch op codes is ignored in IDLE
        for (int k = 5; k < 16; k++) begin
            if (k == 5 || k == 6) continue;
            mdu_op = 4'(k); start = 1'b1; A = $urandom; B = $urandom;
            tick();
            check("bad_op busy", {31'd0, busy}, 32'd0);
            check("bad_op hi", HI, m_hi);
            check("bad_op lo", LO, m_lo);
        end
        start = 1'b0; mdu_op = 4'd0;

        // Reset mid divide: abort, no late write, then a fresh MULT
        mdu_op = 4'd3; A = 32'd100; B = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; mdu_op = 4'd0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst hi", HI, 32'd0);
        check("midrst lo", LO, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("postrst busy", {31'd0, busy}, 32'd0);
            check("postrst hi", HI, 32'd0);
            check("postrst lo", LO, 32'd0);
        end
        run_md("mult_2x3", 4'd1, 32'd2, 32'd3);
        check("mult_2x3 lo_const", LO, 32'd6);
        check("mult_2x3 hi_const", HI, 32'd0);

        // Randomised traffic
        for (int it = 0; it < 60; it++) begin
            op = 4'($urandom_range(1, 6));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            if (op >= 4'd5) begin
                mt(op, ra);
                check("rnd mt hi", HI, m_hi);
                check("rnd mt lo", LO, m_lo);
            end else begin
                run_md("rnd", op, ra, rb);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
